// File: rtl/exe_mem_reg_pkg.sv
// Shared core definitions for the EXE/MEM boundary: exception codes,
// memory access size encodings and the alignment helper.
package exe_mem_reg_pkg;

    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_OV   = 5'h0C;
    localparam logic [4:0] EXC_TR   = 5'h0D;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_e;

    // Byte accesses never fault; the unused encoding is treated as aligned.
    function automatic logic addr_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            MEM_HALF: mis = addr_lo[0];
            MEM_WORD: mis = |addr_lo;
            default:  mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/exe_mem_reg_ex_detect.sv
// Combinational exception detection for the instruction in EXE.
// Trap detection is compiled in only when TRAP_INSN_EN is defined.
module exe_ex_detect
    import exe_mem_reg_pkg::*;
(
    input  logic        valid_i,
    input  logic        ex_in_i,
    input  logic [4:0]  excode_in_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] alu_result_i,
    input  logic        ov_chk_i,
    input  logic        alu_overflow_i,
    input  logic [5:0]  trap_op_i,
    input  logic [5:0]  trap_flags_i,
    input  logic        mem_re_i,
    input  logic        mem_we_i,
    input  logic [1:0]  mem_size_i,
    output logic        ex_o,
    output logic [4:0]  excode_o,
    output logic [31:0] badvaddr_o
);

    logic trap_hit_s;
    logic misalign_s;

`ifdef TRAP_INSN_EN
    assign trap_hit_s = |(trap_op_i & trap_flags_i);
`else
    // Compare flags are still consumed, but can never raise Tr in this build.
    assign trap_hit_s = 1'b0 & (|(trap_op_i & trap_flags_i));
`endif

    assign misalign_s = addr_misaligned(mem_size_i, alu_result_i[1:0]);

    // Priority chain: upstream > Ov > Tr > address error.
    always_comb begin
        ex_o       = 1'b0;
        excode_o   = 5'h00;
        badvaddr_o = 32'h0000_0000;
        if (!valid_i) begin
            ex_o = 1'b0;
        end else if (ex_in_i) begin
            ex_o       = 1'b1;
            excode_o   = excode_in_i;
            badvaddr_o = (excode_in_i == EXC_ADEL) ? pc_i : 32'h0000_0000;
        end else if (ov_chk_i && alu_overflow_i) begin
            ex_o     = 1'b1;
            excode_o = EXC_OV;
        end else if (trap_hit_s) begin
            ex_o     = 1'b1;
            excode_o = EXC_TR;
        end else if (mem_re_i && misalign_s) begin
            ex_o       = 1'b1;
            excode_o   = EXC_ADEL;
            badvaddr_o = alu_result_i;
        end else if (mem_we_i && misalign_s) begin
            ex_o       = 1'b1;
            excode_o   = EXC_ADES;
            badvaddr_o = alu_result_i;
        end else begin
            ex_o = 1'b0;
        end
    end

endmodule

// File: rtl/exe_mem_reg.sv
// EXE->MEM pipeline register with exception capture and flush handling.
// Optional trap detection: define TRAP_INSN_EN.
module exe_mem_reg
    import exe_mem_reg_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        es_valid,
    input  logic [31:0] es_pc,
    input  logic [31:0] es_alu_result,
    input  logic        es_alu_overflow,
    input  logic        es_ov_chk,
    input  logic        es_trap_lt,
    input  logic        es_trap_ltu,
    input  logic        es_trap_ge,
    input  logic        es_trap_geu,
    input  logic        es_trap_eq,
    input  logic        es_trap_neq,
    input  logic [5:0]  es_trap_op,
    input  logic        es_mem_re,
    input  logic        es_mem_we,
    input  logic [1:0]  es_mem_size,
    input  logic [4:0]  es_dest,
    input  logic        es_ex_in,
    input  logic [4:0]  es_excode_in,
    input  logic        ms_allowin,
    output logic        es_allowin,
    output logic        es_ex_now,
    output logic        ms_valid,
    output logic        ms_ex,
    output logic        ms_mem_re,
    output logic        ms_mem_we,
    output logic [4:0]  ms_excode,
    output logic [31:0] ms_pc,
    output logic [31:0] ms_alu_result,
    output logic [31:0] ms_badvaddr,
    output logic [4:0]  ms_dest,
    output logic [1:0]  ms_mem_size
);

    logic        ex_det_s;
    logic [4:0]  ex_code_s;
    logic [31:0] ex_bad_s;
    logic        load_s;

    logic        ms_valid_q,   ms_valid_d;
    logic        ex_block_q,   ex_block_d;
    logic        ms_ex_q,      ms_ex_d;
    logic        ms_mem_re_q,  ms_mem_re_d;
    logic        ms_mem_we_q,  ms_mem_we_d;
    logic [4:0]  ms_excode_q,  ms_excode_d;
    logic [31:0] ms_pc_q,      ms_pc_d;
    logic [31:0] ms_alu_q,     ms_alu_d;
    logic [31:0] ms_bad_q,     ms_bad_d;
    logic [4:0]  ms_dest_q,    ms_dest_d;
    logic [1:0]  ms_size_q,    ms_size_d;

    exe_ex_detect u_ex_detect (
        .valid_i        (es_valid),
        .ex_in_i        (es_ex_in),
        .excode_in_i    (es_excode_in),
        .pc_i           (es_pc),
        .alu_result_i   (es_alu_result),
        .ov_chk_i       (es_ov_chk),
        .alu_overflow_i (es_alu_overflow),
        .trap_op_i      (es_trap_op),
        .trap_flags_i   ({es_trap_ltu, es_trap_lt, es_trap_geu, es_trap_ge, es_trap_neq, es_trap_eq}),
        .mem_re_i       (es_mem_re),
        .mem_we_i       (es_mem_we),
        .mem_size_i     (es_mem_size),
        .ex_o           (ex_det_s),
        .excode_o       (ex_code_s),
        .badvaddr_o     (ex_bad_s)
    );

    assign es_allowin = !ms_valid_q || ms_allowin;
    assign load_s     = es_allowin && es_valid;
    assign es_ex_now  = ex_det_s && !ex_block_q && !flush;

    // Next-state: flush wins over the handshake; blocked instructions enter as bubbles.
    always_comb begin
        ms_valid_d  = ms_valid_q;
        ex_block_d  = ex_block_q;
        ms_ex_d     = ms_ex_q;
        ms_mem_re_d = ms_mem_re_q;
        ms_mem_we_d = ms_mem_we_q;
        ms_excode_d = ms_excode_q;
        ms_pc_d     = ms_pc_q;
        ms_alu_d    = ms_alu_q;
        ms_bad_d    = ms_bad_q;
        ms_dest_d   = ms_dest_q;
        ms_size_d   = ms_size_q;

        if (flush) begin
            ms_valid_d = 1'b0;
            ex_block_d = 1'b0;
        end else if (es_allowin) begin
            ms_valid_d = es_valid && !ex_block_q;
            ex_block_d = ex_block_q || (es_valid && ex_det_s);
        end else begin
            ms_valid_d = ms_valid_q;
        end

        if (load_s) begin
            ms_ex_d     = ex_det_s;
            ms_excode_d = ex_det_s ? ex_code_s : 5'h00;
            ms_mem_re_d = es_mem_re && !ex_det_s;
            ms_mem_we_d = es_mem_we && !ex_det_s;
            ms_dest_d   = ex_det_s ? 5'd0 : es_dest;
            ms_pc_d     = es_pc;
            ms_alu_d    = es_alu_result;
            ms_bad_d    = ex_bad_s;
            ms_size_d   = es_mem_size;
        end else begin
            ms_ex_d = ms_ex_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid_q  <= 1'b0;
            ex_block_q  <= 1'b0;
            ms_ex_q     <= 1'b0;
            ms_mem_re_q <= 1'b0;
            ms_mem_we_q <= 1'b0;
            ms_excode_q <= 5'h00;
            ms_pc_q     <= 32'h0000_0000;
            ms_alu_q    <= 32'h0000_0000;
            ms_bad_q    <= 32'h0000_0000;
            ms_dest_q   <= 5'd0;
            ms_size_q   <= 2'd0;
        end else begin
            ms_valid_q  <= ms_valid_d;
            ex_block_q  <= ex_block_d;
            ms_ex_q     <= ms_ex_d;
            ms_mem_re_q <= ms_mem_re_d;
            ms_mem_we_q <= ms_mem_we_d;
            ms_excode_q <= ms_excode_d;
            ms_pc_q     <= ms_pc_d;
            ms_alu_q    <= ms_alu_d;
            ms_bad_q    <= ms_bad_d;
            ms_dest_q   <= ms_dest_d;
            ms_size_q   <= ms_size_d;
        end
    end

    assign ms_valid      = ms_valid_q;
    assign ms_ex         = ms_ex_q;
    assign ms_mem_re     = ms_mem_re_q;
    assign ms_mem_we     = ms_mem_we_q;
    assign ms_excode     = ms_excode_q;
    assign ms_pc         = ms_pc_q;
    assign ms_alu_result = ms_alu_q;
    assign ms_badvaddr   = ms_bad_q;
    assign ms_dest       = ms_dest_q;
    assign ms_mem_size   = ms_size_q;

endmodule

// File: tb/tb_exe_mem_reg.sv
// Self-checking bench for exe_mem_reg: directed scenarios followed by
// randomized traffic checked against a behavioural model.
module tb_exe_mem_reg;

    logic        clk, reset, flush, es_valid;
    logic [31:0] es_pc, es_alu_result;
    logic        es_alu_overflow, es_ov_chk;
    logic        es_trap_lt, es_trap_ltu, es_trap_ge, es_trap_geu, es_trap_eq, es_trap_neq;
    logic [5:0]  es_trap_op;
    logic        es_mem_re, es_mem_we;
    logic [1:0]  es_mem_size;
    logic [4:0]  es_dest;
    logic        es_ex_in;
    logic [4:0]  es_excode_in;
    logic        ms_allowin, es_allowin, es_ex_now;
    logic        ms_valid, ms_ex, ms_mem_re, ms_mem_we;
    logic [4:0]  ms_excode, ms_dest;
    logic [31:0] ms_pc, ms_alu_result, ms_badvaddr;
    logic [1:0]  ms_mem_size;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_valid, m_block, m_ex, m_re, m_we;
    logic [4:0]  m_excode, m_dest;
    logic [31:0] m_pc, m_alu, m_bad;
    logic [1:0]  m_size;
    bit          r_ex;
    logic [4:0]  r_code;
    logic [31:0] r_bad;
    logic [31:0] held_pc;

    exe_mem_reg dut (
        .clk(clk), .reset(reset), .flush(flush), .es_valid(es_valid),
        .es_pc(es_pc), .es_alu_result(es_alu_result),
        .es_alu_overflow(es_alu_overflow), .es_ov_chk(es_ov_chk),
        .es_trap_lt(es_trap_lt), .es_trap_ltu(es_trap_ltu), .es_trap_ge(es_trap_ge),
        .es_trap_geu(es_trap_geu), .es_trap_eq(es_trap_eq), .es_trap_neq(es_trap_neq),
        .es_trap_op(es_trap_op), .es_mem_re(es_mem_re), .es_mem_we(es_mem_we),
        .es_mem_size(es_mem_size), .es_dest(es_dest), .es_ex_in(es_ex_in),
        .es_excode_in(es_excode_in), .ms_allowin(ms_allowin), .es_allowin(es_allowin),
        .es_ex_now(es_ex_now), .ms_valid(ms_valid), .ms_ex(ms_ex), .ms_mem_re(ms_mem_re),
        .ms_mem_we(ms_mem_we), .ms_excode(ms_excode), .ms_pc(ms_pc),
        .ms_alu_result(ms_alu_result), .ms_badvaddr(ms_badvaddr), .ms_dest(ms_dest),
        .ms_mem_size(ms_mem_size)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        flush = 1'b0; es_valid = 1'b0; es_pc = 32'h0; es_alu_result = 32'h0;
        es_alu_overflow = 1'b0; es_ov_chk = 1'b0;
        {es_trap_lt, es_trap_ltu, es_trap_ge, es_trap_geu, es_trap_eq, es_trap_neq} = 6'b0;
        es_trap_op = 6'b0; es_mem_re = 1'b0; es_mem_we = 1'b0; es_mem_size = 2'd0;
        es_dest = 5'd0; es_ex_in = 1'b0; es_excode_in = 5'd0; ms_allowin = 1'b1;
    endtask

    task automatic set_insn(input logic [31:0] pc, input logic [31:0] addr,
                            input bit re, input bit we, input logic [1:0] size, input logic [4:0] dest);
        es_valid = 1'b1; es_pc = pc; es_alu_result = addr;
        es_mem_re = re; es_mem_we = we; es_mem_size = size; es_dest = dest;
    endtask

    task automatic model_reset();
        m_valid = 0; m_block = 0; m_ex = 0; m_re = 0; m_we = 0;
        m_excode = 5'd0; m_dest = 5'd0; m_pc = 32'h0; m_alu = 32'h0; m_bad = 32'h0; m_size = 2'd0;
    endtask

    // Exception the spec's rules assign to the instruction currently in EXE.
    task automatic ref_detect();
        bit          flag [6];
        bit          trap_any;
        int unsigned nbytes;
        flag[0] = es_trap_eq;  flag[1] = es_trap_neq; flag[2] = es_trap_ge;
        flag[3] = es_trap_geu; flag[4] = es_trap_lt;  flag[5] = es_trap_ltu;
        trap_any = 0;
        for (int i = 0; i < 6; i++) if (es_trap_op[i] && flag[i]) trap_any = 1;
`ifndef TRAP_INSN_EN
        trap_any = 0;
`endif
        nbytes = (es_mem_size == 2'd1) ? 2 : (es_mem_size == 2'd2) ? 4 : 1;
        r_ex = 1; r_code = 5'd0; r_bad = 32'h0;
        if (!es_valid) r_ex = 0;
        else if (es_ex_in) begin
            r_code = es_excode_in;
            if (es_excode_in == 5'd4) r_bad = es_pc;
        end
        else if (es_ov_chk && es_alu_overflow) r_code = 5'd12;
        else if (trap_any) r_code = 5'd13;
        else if ((es_mem_re || es_mem_we) && (es_alu_result % nbytes) != 0) begin
            r_code = es_mem_re ? 5'd4 : 5'd5;
            r_bad = es_alu_result;
        end
        else r_ex = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".allowin"}, es_allowin, 1);
        chk({tag, ".valid"}, ms_valid, 0);
        chk({tag, ".ex"}, ms_ex, 0);
        chk({tag, ".re_we"}, {ms_mem_re, ms_mem_we}, 0);
        chk({tag, ".excode"}, ms_excode, 0);
        chk({tag, ".pc"}, ms_pc, 0);
        chk({tag, ".alu"}, ms_alu_result, 0);
        chk({tag, ".bad"}, ms_badvaddr, 0);
        chk({tag, ".dest"}, ms_dest, 0);
        chk({tag, ".size"}, ms_mem_size, 0);
    endtask

    // One clock: inputs are set at the falling edge before this is called.
    task automatic cycle(input string tag);
        bit allow;
        #1;
        ref_detect();
        allow = !m_valid || ms_allowin;
        chk({tag, ".es_allowin"}, es_allowin, allow);
        chk({tag, ".es_ex_now"}, es_ex_now, r_ex && !m_block && !flush);
        if (flush) begin
            m_valid = 0; m_block = 0;
        end else if (allow) begin
            m_valid = es_valid && !m_block;
            if (es_valid && r_ex) m_block = 1;
        end
        if (allow && es_valid) begin
            m_ex = r_ex; m_excode = r_ex ? r_code : 5'd0; m_bad = r_bad;
            m_re = es_mem_re && !r_ex; m_we = es_mem_we && !r_ex;
            m_dest = r_ex ? 5'd0 : es_dest;
            m_pc = es_pc; m_alu = es_alu_result; m_size = es_mem_size;
        end
        @(posedge clk);
        #1;
        chk({tag, ".ms_valid"}, ms_valid, m_valid);
        if (m_valid) begin
            chk({tag, ".ms_ex"}, ms_ex, m_ex);
            chk({tag, ".ms_excode"}, ms_excode, m_excode);
            chk({tag, ".ms_re_we"}, {ms_mem_re, ms_mem_we}, {m_re, m_we});
            chk({tag, ".ms_pc"}, ms_pc, m_pc);
            chk({tag, ".ms_alu"}, ms_alu_result, m_alu);
            chk({tag, ".ms_bad"}, ms_badvaddr, m_bad);
            chk({tag, ".ms_dest"}, ms_dest, m_dest);
            chk({tag, ".ms_size"}, ms_mem_size, m_size);
        end
        @(negedge clk);
    endtask

    initial begin
        set_idle();
        model_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;

        // add overflow on a store
        set_insn(32'h400, 32'h8000_0000, 0, 1, 2'd2, 5'd5);
        es_ov_chk = 1'b1; es_alu_overflow = 1'b1;
        cycle("ov");
        chk("ov.ex", ms_ex, 1); chk("ov.code", ms_excode, 32'h0C); chk("ov.we", ms_mem_we, 0);
        set_idle(); flush = 1'b1; cycle("ov.flush");

        // lw misaligned
        set_idle(); set_insn(32'h404, 32'h1002, 1, 0, 2'd2, 5'd6); cycle("lw");
        chk("lw.code", ms_excode, 32'h04); chk("lw.bad", ms_badvaddr, 32'h0000_1002);
        set_idle(); flush = 1'b1; cycle("lw.flush");
        // sh misaligned
        set_idle(); set_insn(32'h408, 32'h1001, 0, 1, 2'd1, 5'd7); cycle("sh");
        chk("sh.code", ms_excode, 32'h05);
        set_idle(); flush = 1'b1; cycle("sh.flush");
        // sb never faults
        set_idle(); set_insn(32'h40C, 32'h1003, 0, 1, 2'd0, 5'd8); cycle("sb");
        chk("sb.ex", ms_ex, 0); chk("sb.we", ms_mem_we, 1);

        // teq with equal operands
        set_idle(); set_insn(32'h410, 32'h0, 0, 0, 2'd0, 5'd9);
        es_trap_op = 6'b000001; es_trap_eq = 1'b1; cycle("teq");
`ifdef TRAP_INSN_EN
        chk("teq.code", ms_excode, 32'h0D);
`else
        chk("teq.ex", ms_ex, 0);
`endif
        set_idle(); flush = 1'b1; cycle("teq.flush");

        // back-pressure: hold three cycles, then release
        set_idle(); set_insn(32'h500, 32'h2000, 1, 0, 2'd2, 5'd10); cycle("bp.load");
        held_pc = ms_pc;
        set_insn(32'h504, 32'h2004, 0, 1, 2'd2, 5'd11); ms_allowin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle("bp.hold");
            chk("bp.allowin", es_allowin, 0);
            chk("bp.pc", ms_pc, 32'h500);
        end
        ms_allowin = 1'b1; cycle("bp.release");
        chk("bp.newpc", ms_pc, 32'h504);

        // ex_block: excepting instr, then two bubbles, then flush clears it
        set_idle(); set_insn(32'h600, 32'h3000, 0, 0, 2'd0, 5'd1);
        es_ov_chk = 1'b1; es_alu_overflow = 1'b1; cycle("blk.ex");
        set_idle(); set_insn(32'h604, 32'h3004, 1, 0, 2'd2, 5'd2); cycle("blk.1");
        chk("blk.1.valid", ms_valid, 0);
        set_insn(32'h608, 32'h3009, 1, 0, 2'd2, 5'd3); cycle("blk.2");
        chk("blk.2.valid", ms_valid, 0);
        set_insn(32'h60C, 32'h3010, 0, 1, 2'd2, 5'd4); flush = 1'b1; cycle("blk.flush");
        chk("blk.flush.valid", ms_valid, 0);
        set_idle(); set_insn(32'h610, 32'h3014, 0, 1, 2'd2, 5'd4); cycle("blk.after");
        chk("blk.after.valid", ms_valid, 1);

        // asynchronous reset pulse between edges
        set_idle(); set_insn(32'h700, 32'h4000, 1, 0, 2'd2, 5'd12); cycle("ar.load");
        set_idle();
        #2 reset = 1'b1;
        #1 check_reset_vals("async_reset");
        #1 reset = 1'b0;
        model_reset();
        @(negedge clk);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            set_idle();
            ms_allowin = ($urandom % 4) != 0;
            flush = ($urandom % 16) == 0;
            es_valid = ($urandom % 4) != 0;
            es_pc = $urandom & 32'hFFFF_FFFC;
            es_alu_result = $urandom;
            case ($urandom % 3)
                0: begin es_mem_re = 1'b0; es_mem_we = 1'b0; end
                1: es_mem_re = 1'b1;
                default: es_mem_we = 1'b1;
            endcase
            es_mem_size = 2'($urandom % 3);
            es_ov_chk = ($urandom % 4) == 0;
            es_alu_overflow = 1'($urandom);
            es_trap_op = (($urandom % 3) == 0) ? 6'(6'd1 << ($urandom % 6)) : 6'd0;
            {es_trap_lt, es_trap_ltu, es_trap_ge, es_trap_geu, es_trap_eq, es_trap_neq} = 6'($urandom);
            es_ex_in = ($urandom % 10) == 0;
            es_excode_in = (($urandom % 2) == 0) ? 5'd4 : 5'($urandom);
            es_dest = 5'($urandom);
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exe_mem_reg.md
EXE_MEM_REG -- requirements
Module: exe_mem_reg

Interface
REQ-001 SHALL have: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: flush  in  1  exception/eret flush from WB.
REQ-004 SHALL have: es_valid  in  1  EXE holds a valid instruction.
REQ-005 SHALL have: es_pc, es_alu_result  in  32 each  PC and ALU result (also the memory address).
REQ-006 SHALL have: es_alu_overflow  in  1  ALU overflow flag.
REQ-007 SHALL have: es_ov_chk  in  1  instruction is add/addi/sub (overflow trapping).
REQ-008 SHALL have: es_trap_lt, es_trap_ltu, es_trap_ge, es_trap_geu, es_trap_eq, es_trap_neq  in  1 each  ALU compare flags.
REQ-009 SHALL have: es_trap_op  in  6  one-hot {tltu,tlt,tgeu,tge,tne,teq}, bit0=teq.
REQ-010 SHALL have: es_mem_re, es_mem_we  in  1 each; es_mem_size  in  2 (0 byte, 1 half, 2 word).
REQ-011 SHALL have: es_dest  in  5; es_ex_in  in  1; es_excode_in  in  5  upstream exception.
REQ-012 SHALL have: ms_allowin  in  1; es_allowin  out  1.
REQ-013 SHALL have: es_ex_now  out  1  combinational exception of the current EXE instruction (store suppression).
REQ-014 SHALL have: ms_valid, ms_ex, ms_mem_re, ms_mem_we  out  1 each; ms_excode  out  5; ms_pc, ms_alu_result, ms_badvaddr  out  32; ms_dest  out  5; ms_mem_size  out  2.

Function
REQ-015 es_allowin SHALL equal !ms_valid || ms_allowin.
REQ-016 When es_allowin and es_valid, all ms_* payload SHALL load on the next edge (1-cycle latency); ms_valid<=1.
REQ-017 When es_allowin and !es_valid, ms_valid SHALL go 0 on the next edge; payload is don't-care.
REQ-018 When !es_allowin, all ms_* SHALL hold.
REQ-019 Exception detect (combinational, gated by es_valid) SHALL have priority: es_ex_in (pass es_excode_in) > Ov 0x0C (es_ov_chk & es_alu_overflow) > Tr 0x0D (any es_trap_op bit AND its flag) > AdEL 0x04 (load) / AdES 0x05 (store) misaligned.
REQ-020 Misaligned: half with addr[0]=1; word with addr[1:0]!=0; byte never.
REQ-021 ms_badvaddr SHALL be es_alu_result on AdEL/AdES, else es_pc when es_ex_in with excode 0x04, else 0.
REQ-022 On a latched exception, ms_mem_we and ms_mem_re SHALL be 0 and ms_dest 0.
REQ-023 A sticky ex_block bit SHALL set when an excepting instruction is latched; while set, each newly latched instruction SHALL load with ms_valid=0.
REQ-024 flush SHALL take priority over a same-cycle load: ms_valid<=0, ex_block<=0.
REQ-025 es_ex_now SHALL be 0 when ex_block=1 or flush=1.

Reset
REQ-026 On reset: ms_valid=0, ex_block=0, ms_ex=0, ms_mem_re=0, ms_mem_we=0, ms_excode=0, ms_dest=0, ms_mem_size=0, ms_pc=0, ms_alu_result=0, ms_badvaddr=0.
REQ-027 Reset asserted mid-handshake SHALL drop any in-flight instruction; es_allowin=1 during reset.

Configuration
REQ-028 Macro TRAP_INSN_EN: defined -> Tr detection per REQ-019; undefined -> es_trap_* and es_trap_op ignored, Tr never raised.

Structure
REQ-029 Excode constants (0x04, 0x05, 0x0C, 0x0D) and mem_size encodings SHALL live in the shared core package.
REQ-030 Exception priority/alignment logic SHALL be sub-module exe_ex_detect (combinational); registers stay in exe_mem_reg.

Verification
REQ-031 add overflow: es_ov_chk=1, overflow=1, ms_allowin=1 -> next cycle ms_ex=1, ms_excode=0x0C, ms_mem_we=0.
REQ-032 lw addr 0x1002 -> ms_excode=0x04, ms_badvaddr=0x00001002; sh addr 0x1001 -> 0x05; sb 0x1003 -> no exception.
REQ-033 teq with trap_eq=1 and TRAP_INSN_EN -> excode 0x0D; macro undefined -> ms_ex=0.
REQ-034 ms_allowin=0, ms_valid=1 -> es_allowin=0, ms_* hold 3 cycles; release -> new payload in 1 cycle.
REQ-035 Exception latched, next two valid instrs -> ms_valid=0 for both; flush same cycle as load -> ms_valid=0, ex_block=0.
REQ-036 Reset pulse between edges with ms_valid=1 -> ms_valid=0 immediately, all outputs at reset values.
